// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared types and helpers for stream_demux.
// Optional feature macro: STREAM_DEMUX_COUNT_EN (drain counter width).
package stream_demux_pkg;

   localparam int CNT_W  = 16;
   localparam int MAX_CH = 64;

   typedef enum logic {
      ST_EMPTY,
      ST_FULL
   } state_t;

   // One-hot of sel, or all-zero when sel is not below num_ch.
   function automatic logic [MAX_CH-1:0] onehot_dec(
      input int unsigned sel,
      input int unsigned num_ch
   );
      logic [MAX_CH-1:0] v;
      v = '0;
      if (sel < num_ch) begin
         v[sel[5:0]] = 1'b1;
      end
      return v;
   endfunction

endpackage

// File: rtl/stream_demux_onehot_decoder.sv
// onehot_decoder: SEL_W -> NUM_CH one-hot decode with enable.
// Out-of-range selects and a low enable both give all-zero.
module onehot_decoder
   import stream_demux_pkg::*;
#(
   parameter int SEL_W  = 2,
   parameter int NUM_CH = 4
) (
   input  logic              i_en,
   input  logic [SEL_W-1:0]  i_sel,
   output logic [NUM_CH-1:0] o_onehot
);

   // Pure decode; only the low NUM_CH bits of the helper matter.
   always_comb begin
      o_onehot = '0;
      if (i_en) begin
         o_onehot = NUM_CH'(onehot_dec(32'(i_sel), 32'(NUM_CH)));
      end
   end

endmodule

// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-NUM_CH valid/ready demultiplexer.
// Optional macro STREAM_DEMUX_COUNT_EN adds a saturating beat_cnt.
module stream_demux
   import stream_demux_pkg::*;
#(
   parameter int SEL_W  = 2,
   parameter int NUM_CH = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [SEL_W-1:0]  in_sel,
   input  logic [DATA_W-1:0] in_data,
   output logic [NUM_CH-1:0] out_valid,
   input  logic [NUM_CH-1:0] out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              err,
   input  logic              err_clr
`ifdef STREAM_DEMUX_COUNT_EN
   ,
   output logic [CNT_W-1:0]  beat_cnt
`endif
);

   state_t            r_state;
   logic [SEL_W-1:0]  r_ch;
   logic [DATA_W-1:0] r_data;
   logic              r_err;

   logic              w_full;
   logic              w_drain;
   logic              w_xfer;
   logic              w_in_range;

   onehot_decoder #(
      .SEL_W  (SEL_W),
      .NUM_CH (NUM_CH)
   ) u_dec (
      .i_en     (w_full),
      .i_sel    (r_ch),
      .o_onehot (out_valid)
   );

   // Handshake terms; only the held channel's ready can drain.
   always_comb begin
      w_full     = (r_state == ST_FULL);
      w_drain    = |(out_valid & out_ready);
      w_in_range = (32'(in_sel) < 32'(NUM_CH));
      in_ready   = enable && (!w_full || w_drain);
      w_xfer     = in_valid && in_ready;
      out_data   = r_data;
      err        = r_err;
   end

   // Hold register FSM: in-range transfers load, drains empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
         r_ch    <= '0;
         r_data  <= '0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_xfer && w_in_range) begin
                  r_state <= ST_FULL;
                  r_ch    <= in_sel;
                  r_data  <= in_data;
               end
            end
            ST_FULL: begin
               if (w_xfer && w_in_range) begin
                  r_ch    <= in_sel;
                  r_data  <= in_data;
               end else if (w_drain) begin
                  r_state <= ST_EMPTY;
               end
            end
            default: r_state <= ST_EMPTY;
         endcase
      end
   end

   // Sticky out-of-range flag; a new set beats a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else if (w_xfer && !w_in_range) begin
         r_err <= 1'b1;
      end else if (err_clr) begin
         r_err <= 1'b0;
      end
   end

`ifdef STREAM_DEMUX_COUNT_EN
   logic [CNT_W-1:0] r_cnt;

   // Saturating drain count; clear restarts at 1 if a drain coincides.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (err_clr) begin
         r_cnt <= w_drain ? CNT_W'(1) : '0;
      end else if (w_drain && (r_cnt != '1)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign beat_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: scoreboard bench for stream_demux (NUM_CH=4 and 3).
// Define STREAM_DEMUX_COUNT_EN to also exercise beat_cnt.
module tb_stream_demux;

   typedef struct {
      logic [1:0] ch;
      logic [7:0] data;
   } beat_t;

   logic       clk;
   logic       rst_n;
   logic       enable;
   logic       in_valid;
   logic [1:0] in_sel;
   logic [7:0] in_data;
   logic [3:0] out_ready;
   logic       err_clr;

   logic       in_ready;
   logic [3:0] out_valid;
   logic [7:0] out_data;
   logic       err;

   logic       in_ready3;
   logic [2:0] out_valid3;
   logic [7:0] out_data3;
   logic       err3;

`ifdef STREAM_DEMUX_COUNT_EN
   logic [15:0] beat_cnt;
   logic [15:0] beat_cnt3;
`endif

   int total;
   int bad;
   beat_t q[$];

   stream_demux #(.SEL_W(2), .NUM_CH(4), .DATA_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sel    (in_sel),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .err       (err),
      .err_clr   (err_clr)
`ifdef STREAM_DEMUX_COUNT_EN
      ,
      .beat_cnt  (beat_cnt)
`endif
   );

   stream_demux #(.SEL_W(2), .NUM_CH(3), .DATA_W(8)) dut3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .in_valid  (in_valid),
      .in_ready  (in_ready3),
      .in_sel    (in_sel),
      .in_data   (in_data),
      .out_valid (out_valid3),
      .out_ready (out_ready[2:0]),
      .out_data  (out_data3),
      .err       (err3),
      .err_clr   (err_clr)
`ifdef STREAM_DEMUX_COUNT_EN
      ,
      .beat_cnt  (beat_cnt3)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model for the 4-channel DUT, evaluated mid-cycle.
   always @(negedge clk) begin
      logic       exp_rdy;
      logic [3:0] exp_v;
      logic       drn;
      beat_t      b;
      if (rst_n) begin
         drn = (q.size() != 0) && out_ready[q[0].ch];
         exp_rdy = enable && ((q.size() == 0) || drn);
         exp_v = 4'b0000;
         if (q.size() != 0) exp_v = 4'b0001 << q[0].ch;
         total++;
         if (in_ready !== exp_rdy) begin
            bad++;
            $display("FAIL sb_in_ready got=%b exp=%b t=%0t",
                     in_ready, exp_rdy, $time);
         end
         total++;
         if (out_valid !== exp_v) begin
            bad++;
            $display("FAIL sb_out_valid got=%b exp=%b t=%0t",
                     out_valid, exp_v, $time);
         end
         if (q.size() != 0) begin
            total++;
            if (out_data !== q[0].data) begin
               bad++;
               $display("FAIL sb_out_data got=%h exp=%h t=%0t",
                        out_data, q[0].data, $time);
            end
         end
         if (drn) void'(q.pop_front());
         if (exp_rdy && in_valid) begin
            b.ch   = in_sel;
            b.data = in_data;
            q.push_back(b);
         end
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      enable    = 1'b1;
      in_valid  = 1'b0;
      in_sel    = 2'd0;
      in_data   = 8'h00;
      out_ready = 4'hF;
      err_clr   = 1'b0;
      #23;
      total++;
      if (out_valid !== 4'b0000 || out_valid3 !== 3'b000) begin
         bad++;
         $display("FAIL rst_valid got=%b/%b exp=0", out_valid, out_valid3);
      end
      total++;
      if (out_data !== 8'h00 || err !== 1'b0 || err3 !== 1'b0) begin
         bad++;
         $display("FAIL rst_data_err got=%h/%b/%b exp=00/0/0",
                  out_data, err, err3);
      end
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL rst_in_ready got=%b exp=1", in_ready);
      end
      nxt();
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      nxt();
      in_valid = 1'b1;
      in_sel   = 2'd2;
      in_data  = 8'hA5;
      mid();
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL basic_in_ready got=%b exp=1", in_ready);
      end
      nxt();
      in_valid = 1'b0;
      mid();
      total++;
      if (out_valid !== 4'b0100 || out_data !== 8'hA5) begin
         bad++;
         $display("FAIL basic_route got=%b/%h exp=0100/a5",
                  out_valid, out_data);
      end
      nxt();
      mid();
      total++;
      if (out_valid !== 4'b0000) begin
         bad++;
         $display("FAIL basic_empty got=%b exp=0000", out_valid);
      end
   endtask

   task automatic test_backpressure();
      nxt();
      out_ready = 4'b1101;
      in_valid  = 1'b1;
      in_sel    = 2'd1;
      in_data   = 8'h3C;
      nxt();
      in_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         mid();
         total++;
         if (out_valid !== 4'b0010 || out_data !== 8'h3C) begin
            bad++;
            $display("FAIL bp_hold got=%b/%h exp=0010/3c k=%0d",
                     out_valid, out_data, k);
         end
         total++;
         if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_in_ready got=%b exp=0 k=%0d", in_ready, k);
         end
         nxt();
         if (k < 4) out_ready = 4'($urandom) & 4'b1101;
         else       out_ready = 4'b1111;
      end
      mid();
      total++;
      if (in_ready !== 1'b1 || out_valid !== 4'b0010) begin
         bad++;
         $display("FAIL bp_drain got=%b/%b exp=1/0010",
                  in_ready, out_valid);
      end
      nxt();
      mid();
      total++;
      if (out_valid !== 4'b0000) begin
         bad++;
         $display("FAIL bp_after got=%b exp=0000", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] ev;
      logic [7:0] ed;
      for (int i = 0; i < 5; i++) begin
         nxt();
         in_valid = (i < 4);
         in_sel   = 2'(i);
         in_data  = 8'h10 + 8'(i);
         mid();
         if (i < 4) begin
            total++;
            if (in_ready !== 1'b1) begin
               bad++;
               $display("FAIL b2b_ready got=%b exp=1 i=%0d", in_ready, i);
            end
         end
         if (i > 0) begin
            ev = 4'b0001 << (i - 1);
            ed = 8'h10 + 8'(i - 1);
            total++;
            if (out_valid !== ev || out_data !== ed) begin
               bad++;
               $display("FAIL b2b_seq got=%b/%h exp=%b/%h",
                        out_valid, out_data, ev, ed);
            end
         end
      end
      in_valid = 1'b0;
      nxt();
      mid();
      total++;
      if (out_valid !== 4'b0000) begin
         bad++;
         $display("FAIL b2b_end got=%b exp=0000", out_valid);
      end
   endtask

   task automatic test_out_of_range();
      nxt();
      err_clr = 1'b1;
      nxt();
      err_clr = 1'b0;
      mid();
      total++;
      if (err3 !== 1'b0) begin
         bad++;
         $display("FAIL oor_preclear got=%b exp=0", err3);
      end
      nxt();
      in_valid = 1'b1;
      in_sel   = 2'd3;
      in_data  = 8'hFF;
      mid();
      total++;
      if (in_ready3 !== 1'b1 || out_valid3 !== 3'b000 || err3 !== 1'b0) begin
         bad++;
         $display("FAIL oor_accept got=%b/%b/%b exp=1/000/0",
                  in_ready3, out_valid3, err3);
      end
      nxt();
      in_valid = 1'b0;
      mid();
      total++;
      if (err3 !== 1'b1 || out_valid3 !== 3'b000) begin
         bad++;
         $display("FAIL oor_err got=%b/%b exp=1/000", err3, out_valid3);
      end
      total++;
      if (err !== 1'b0) begin
         bad++;
         $display("FAIL oor_err4 got=%b exp=0", err);
      end
      nxt();
      err_clr  = 1'b1;
      in_valid = 1'b1;
      in_sel   = 2'd3;
      in_data  = 8'hEE;
      nxt();
      in_valid = 1'b0;
      mid();
      total++;
      if (err3 !== 1'b1) begin
         bad++;
         $display("FAIL oor_set_wins got=%b exp=1", err3);
      end
      nxt();
      err_clr = 1'b0;
      mid();
      total++;
      if (err3 !== 1'b0) begin
         bad++;
         $display("FAIL oor_clear got=%b exp=0", err3);
      end
   endtask

   task automatic test_enable_reset();
      nxt();
      out_ready = 4'b0000;
      in_valid  = 1'b1;
      in_sel    = 2'd0;
      in_data   = 8'h77;
      nxt();
      in_valid = 1'b0;
      enable   = 1'b0;
      mid();
      total++;
      if (in_ready !== 1'b0 || out_valid !== 4'b0001) begin
         bad++;
         $display("FAIL en_hold got=%b/%b exp=0/0001", in_ready, out_valid);
      end
      nxt();
      out_ready = 4'b1111;
      in_valid  = 1'b1;
      in_sel    = 2'd2;
      in_data   = 8'h44;
      mid();
      total++;
      if (in_ready !== 1'b0) begin
         bad++;
         $display("FAIL en_ready got=%b exp=0", in_ready);
      end
      nxt();
      in_valid = 1'b0;
      mid();
      total++;
      if (out_valid !== 4'b0000) begin
         bad++;
         $display("FAIL en_drain got=%b exp=0000", out_valid);
      end
      nxt();
      enable    = 1'b1;
      out_ready = 4'b0000;
      in_valid  = 1'b1;
      in_sel    = 2'd3;
      in_data   = 8'h99;
      nxt();
      in_valid = 1'b0;
      mid();
      total++;
      if (out_valid !== 4'b1000 || err3 !== 1'b1) begin
         bad++;
         $display("FAIL pre_rst got=%b/%b exp=1000/1", out_valid, err3);
      end
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (out_valid !== 4'b0000 || err3 !== 1'b0 || err !== 1'b0) begin
         bad++;
         $display("FAIL async_rst got=%b/%b/%b exp=0000/0/0",
                  out_valid, err3, err);
      end
      total++;
      if (out_data !== 8'h00) begin
         bad++;
         $display("FAIL async_rst_data got=%h exp=00", out_data);
      end
      q.delete();
      #20;
      nxt();
      rst_n     = 1'b1;
      out_ready = 4'b1111;
   endtask

`ifdef STREAM_DEMUX_COUNT_EN
   task automatic test_count();
      nxt();
      out_ready = 4'b1111;
      in_valid  = 1'b1;
      in_sel    = 2'd0;
      for (int k = 0; k < 70000; k++) begin
         in_data = 8'(k);
         nxt();
      end
      mid();
      total++;
      if (beat_cnt !== 16'hFFFF) begin
         bad++;
         $display("FAIL cnt_sat got=%h exp=ffff", beat_cnt);
      end
      nxt();
      err_clr = 1'b1;
      nxt();
      err_clr  = 1'b0;
      in_valid = 1'b0;
      mid();
      total++;
      if (beat_cnt !== 16'h0001) begin
         bad++;
         $display("FAIL cnt_clr got=%h exp=0001", beat_cnt);
      end
      nxt();
   endtask
`endif

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_basic();
      test_backpressure();
      test_back_to_back();
      test_out_of_range();
      test_enable_reset();
`ifdef STREAM_DEMUX_COUNT_EN
      test_count();
`endif
      repeat (3) nxt();
      mid();
      total++;
      if (q.size() != 0 || out_valid !== 4'b0000) begin
         bad++;
         $display("FAIL final_idle got=%0d/%b exp=0/0000",
                  q.size(), out_valid);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
